// File: rtl/atm_pin_entry.sv
`default_nettype none
// ============================================================================
// Module      : atm_pin_entry
// Description : ATM keypad front-end. Debounces the raw key code, collects
//               PIN digits into a packed BCD word, issues PIN-valid /
//               PIN-error pulses, forwards command keys (13/14/15) as
//               single-cycle strobes and aborts an idle entry on timeout.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               raw_key[3:0]      - raw key (0 none, 1-9, 10=0, 11 CLEAR,
//                                   12 ENTER, 13-15 command)
//               enable            - card present; low forces IDLE
//               key_strobe/code   - one pulse per debounced press
//               digit_count       - digits buffered
//               pin_value         - BCD PIN, first digit in MS nibble
//               pin_valid/error   - ENTER outcome pulses
//               cmd_valid/cmd_key - command key pulse and code
//               timeout           - inactivity abort pulse
//               busy              - high while collecting
// Revision    : 1.0 - initial release
// ============================================================================
module atm_pin_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PIN_DIGITS      = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              raw_key,
    input  logic                    enable,
    output logic                    key_strobe,
    output logic [3:0]              key_code,
    output logic [2:0]              digit_count,
    output logic [4*PIN_DIGITS-1:0] pin_value,
    output logic                    pin_valid,
    output logic                    pin_error,
    output logic                    cmd_valid,
    output logic [3:0]              cmd_key,
    output logic                    timeout,
    output logic                    busy
);

    localparam int                 c_db_w   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_db_w-1:0]  c_db_max = c_db_w'(DEBOUNCE_CYCLES);
    localparam int                 c_to_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_to_w-1:0]  c_to_max = c_to_w'(TIMEOUT_CYCLES);
    localparam int                 c_pin_w  = 4 * PIN_DIGITS;
    localparam logic [2:0]         c_full   = 3'(PIN_DIGITS);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    logic [3:0]        r_last;
    logic [c_db_w-1:0] r_stable;
    logic              r_armed;     // set once the keypad has been released
    logic              r_key_strobe;
    logic [3:0]        r_key_code;

    logic              w_same;
    logic [c_db_w-1:0] w_stable_next;
    logic              w_reach;

    always_comb begin
        w_same = (raw_key == r_last);
        if (!w_same)
            w_stable_next = c_db_w'(1);
        else if (r_stable == c_db_max)
            w_stable_next = r_stable;
        else
            w_stable_next = r_stable + c_db_w'(1);
        // Fires only on the sample that first completes a stable run.
        w_reach = (w_stable_next == c_db_max) && !(w_same && (r_stable == c_db_max));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last       <= 4'd0;
            r_stable     <= '0;
            r_armed      <= 1'b1;
            r_key_strobe <= 1'b0;
            r_key_code   <= 4'd0;
        end else begin
            r_last       <= raw_key;
            r_stable     <= w_stable_next;
            r_key_strobe <= 1'b0;
            if (w_reach) begin
                if (raw_key == 4'd0) begin
                    r_armed <= 1'b1;
                end else if (r_armed) begin
                    r_key_strobe <= 1'b1;
                    r_key_code   <= raw_key;
                    r_armed      <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Key classification of the accepted press
    // ------------------------------------------------------------------
    logic       w_is_digit, w_is_clear, w_is_enter, w_is_cmd, w_full;
    logic [3:0] w_digit;

    always_comb begin
        w_is_digit = (r_key_code >= 4'd1) && (r_key_code <= 4'd10);
        w_is_clear = (r_key_code == 4'd11);
        w_is_enter = (r_key_code == 4'd12);
        w_is_cmd   = (r_key_code >= 4'd13);
        w_digit    = (r_key_code == 4'd10) ? 4'd0 : r_key_code;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic [1:0]        r_state, w_state_next;
    logic [c_to_w-1:0] r_tcnt;
    logic [c_to_w-1:0] w_tcnt_inc;
    logic              w_to_hit;
    logic [c_pin_w-1:0] r_pin_value;
    logic [2:0]        r_digit_count;
    logic              r_locked;    // PIN accepted; value survives card removal
    logic              r_pin_valid, r_pin_error, r_cmd_valid, r_timeout;
    logic [3:0]        r_cmd_key;

    assign w_full     = (r_digit_count == c_full);
    assign w_tcnt_inc = r_tcnt + c_to_w'(1);
    // A press in the terminal cycle takes priority over the abort.
    assign w_to_hit   = (r_state == S_COLLECT) && enable && !r_key_strobe &&
                        (w_tcnt_inc == c_to_max);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (enable) w_state_next = S_COLLECT;
            S_COLLECT: begin
                if (!enable)
                    w_state_next = S_IDLE;
                else if (r_key_strobe && w_is_enter && w_full)
                    w_state_next = S_HOLD;
                else if (w_to_hit)
                    w_state_next = S_HOLD;
            end
            S_HOLD:    if (!enable) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_COLLECT);
    end

    // ------------------------------------------------------------------
    // Buffer, timeout counter and pulse registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pin_value   <= '0;
            r_digit_count <= 3'd0;
            r_locked      <= 1'b0;
            r_tcnt        <= '0;
            r_pin_valid   <= 1'b0;
            r_pin_error   <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_cmd_key     <= 4'd0;
            r_timeout     <= 1'b0;
        end else begin
            r_pin_valid <= 1'b0;
            r_pin_error <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_timeout   <= 1'b0;
            if (!enable) begin
                // Card removal overrides any press in the same cycle.
                r_digit_count <= 3'd0;
                r_tcnt        <= '0;
                if (!r_locked) r_pin_value <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_pin_value   <= '0;
                        r_digit_count <= 3'd0;
                        r_locked      <= 1'b0;
                        r_tcnt        <= '0;
                    end
                    S_COLLECT: begin
                        if (r_key_strobe) begin
                            r_tcnt <= '0;
                            if (w_is_digit) begin
                                if (!w_full) begin
                                    r_pin_value   <= (r_pin_value << 4) | c_pin_w'(w_digit);
                                    r_digit_count <= r_digit_count + 3'd1;
                                end
                            end else if (w_is_clear) begin
                                r_pin_value   <= '0;
                                r_digit_count <= 3'd0;
                            end else if (w_is_enter) begin
                                if (w_full) begin
                                    r_pin_valid <= 1'b1;
                                    r_locked    <= 1'b1;
                                end else begin
                                    r_pin_error   <= 1'b1;
                                    r_pin_value   <= '0;
                                    r_digit_count <= 3'd0;
                                end
                            end else if (w_is_cmd) begin
                                r_cmd_valid <= 1'b1;
                                r_cmd_key   <= r_key_code;
                            end
                        end else if (w_to_hit) begin
                            r_timeout     <= 1'b1;
                            r_pin_value   <= '0;
                            r_digit_count <= 3'd0;
                            r_tcnt        <= '0;
                        end else begin
                            r_tcnt <= w_tcnt_inc;
                        end
                    end
                    S_HOLD: begin
                        r_tcnt <= '0;
                        if (r_key_strobe && w_is_cmd) begin
                            r_cmd_valid <= 1'b1;
                            r_cmd_key   <= r_key_code;
                        end
                    end
                    default: r_tcnt <= '0;
                endcase
            end
        end
    end

    assign key_strobe  = r_key_strobe;
    assign key_code    = r_key_code;
    assign digit_count = r_digit_count;
    assign pin_value   = r_pin_value;
    assign pin_valid   = r_pin_valid;
    assign pin_error   = r_pin_error;
    assign cmd_valid   = r_cmd_valid;
    assign cmd_key     = r_cmd_key;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire
